// File: rtl/pipe_buff_pkg.sv
// pipe_buff_pkg
// Shared definitions for the inter-stage skid buffer: the buffer state
// encoding, the occupancy encoding reported on o_occupancy, and a helper
// that maps one onto the other.
package pipe_buff_pkg;

  // Buffer state. Encoding 2'd3 is unused; if it is ever reached the
  // buffer recovers to EMPTY on the next edge.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buff_state_e;

  localparam logic [1:0] OCC_NONE = 2'd0;
  localparam logic [1:0] OCC_ONE  = 2'd1;
  localparam logic [1:0] OCC_TWO  = 2'd2;

  // The illegal encoding holds no usable entry, so it reports zero.
  function automatic logic [1:0] occ_of(input buff_state_e s);
    case (s)
      ONE:     occ_of = OCC_ONE;
      FULL:    occ_of = OCC_TWO;
      default: occ_of = OCC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Saturating up-counter. It counts on the falling clock edge to match the
// stage buffers it monitors, and it stops at all-ones instead of wrapping.
// Ports:
//   clk   - stage clock (falling-edge active)
//   rst   - asynchronous, active-high reset to zero
//   inc   - add one on this edge unless already saturated
//   count - current count value
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] STEP = 1;
  localparam logic [W-1:0] MAX  = '1;

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != MAX)) begin
      count_d = count_q + STEP;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_skid_buff.sv
// pipe_skid_buff
// Inter-stage pipeline buffer carrying a control field and a data payload
// over a valid/ready handshake. A second (skid) entry lets the upstream
// stage complete a transfer on the same edge that downstream stalls, so
// back-pressure never costs throughput. A flush drops every held entry,
// and a saturating counter records how often the head was stalled.
// All state updates happen on the falling edge of clk.
// Ports:
//   clk, rst            - stage clock, asynchronous active-high reset
//   i_valid/o_ready     - upstream handshake
//   i_ctrl/i_data       - upstream control field and payload
//   o_valid/i_ready     - downstream handshake
//   o_ctrl/o_data       - head control field (0 on bubbles) and payload
//   i_flush             - discard all held entries
//   o_occupancy         - held entries: 0, 1 or 2
//   o_stall_cnt         - edges with a valid head not accepted
module pipe_skid_buff
  import pipe_buff_pkg::*;
#(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_flush,
  output logic [1:0]        o_occupancy,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  buff_state_e       state_q, state_d;
  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic in_fire;
  logic out_fire;
  logic stall_inc;

  // o_ready comes only from registered state so that upstream never sees a
  // combinational path from i_ready.
  assign o_ready  = !rst && (state_q != FULL);
  assign in_fire  = i_valid && o_ready;
  assign out_fire = main_valid_q && i_ready;

  // Flush wins over every transfer. Payload registers keep their contents
  // when entries are dropped; only the valid bits and state change.
  always_comb begin
    state_d      = state_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_ctrl_d  = main_ctrl_q;
    skid_ctrl_d  = skid_ctrl_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;

    if (i_flush) begin
      state_d      = EMPTY;
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d      = ONE;
            main_valid_d = 1'b1;
            main_ctrl_d  = i_ctrl;
            main_data_d  = i_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl_d = i_ctrl;
            main_data_d = i_data;
          end else if (in_fire) begin
            // Head is stuck; park the new entry behind it.
            state_d      = FULL;
            skid_valid_d = 1'b1;
            skid_ctrl_d  = i_ctrl;
            skid_data_d  = i_data;
          end else if (out_fire) begin
            state_d      = EMPTY;
            main_valid_d = 1'b0;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d      = ONE;
            skid_valid_d = 1'b0;
            main_ctrl_d  = skid_ctrl_q;
            main_data_d  = skid_data_q;
          end
        end
        default: begin
          state_d      = EMPTY;
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_ctrl_q  <= '0;
      skid_ctrl_q  <= '0;
      main_data_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_ctrl_q  <= main_ctrl_d;
      skid_ctrl_q  <= skid_ctrl_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  // A flushed head is not counted as a stall even if downstream held off.
  assign stall_inc = main_valid_q && !i_ready && !i_flush;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_inc),
    .count(o_stall_cnt)
  );

  assign o_valid     = main_valid_q;
  assign o_ctrl      = main_valid_q ? main_ctrl_q : '0;
  assign o_data      = main_data_q;
  assign o_occupancy = occ_of(state_q);

endmodule

// File: tb/tb_pipe_skid_buff.sv
// tb_pipe_skid_buff
// Directed bench for pipe_skid_buff with a 3-bit stall counter so that
// saturation is reachable quickly. A table of per-edge vectors covers the
// single-entry, streaming, skid and flush cases; hand-written sequences
// cover stall saturation and asynchronous reset while full.
module tb_pipe_skid_buff;

  localparam int CTRL_W = 4;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 3;

  logic              clk;
  logic              rst;
  logic              i_valid;
  logic              o_ready;
  logic [CTRL_W-1:0] i_ctrl;
  logic [DATA_W-1:0] i_data;
  logic              o_valid;
  logic              i_ready;
  logic [CTRL_W-1:0] o_ctrl;
  logic [DATA_W-1:0] o_data;
  logic              i_flush;
  logic [1:0]        o_occupancy;
  logic [CNT_W-1:0]  o_stall_cnt;

  int checks;
  int failures;

  typedef struct {
    string             name;
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
    logic              ready;
    logic              flush;
    logic              exp_valid;
    logic [CTRL_W-1:0] exp_ctrl;
    logic [DATA_W-1:0] exp_data;
    logic [1:0]        exp_occ;
    logic              exp_ready;
    logic [CNT_W-1:0]  exp_stall;
  } vec_t;

  vec_t vecs[$];

  pipe_skid_buff #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_ctrl     (i_ctrl),
    .i_data     (i_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_ctrl     (o_ctrl),
    .o_data     (o_data),
    .i_flush    (i_flush),
    .o_occupancy(o_occupancy),
    .o_stall_cnt(o_stall_cnt)
  );

  // Free-running clock; the DUT acts on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends on its own.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic v, input logic [CTRL_W-1:0] c,
                               input logic [DATA_W-1:0] d, input logic r,
                               input logic f);
    i_valid = v;
    i_ctrl  = c;
    i_data  = d;
    i_ready = r;
    i_flush = f;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic ev,
                          input logic [CTRL_W-1:0] ec,
                          input logic [DATA_W-1:0] ed, input logic [1:0] eo,
                          input logic er, input logic [CNT_W-1:0] es);
    checkOutput({tag, ".o_valid"}, 64'(o_valid), 64'(ev));
    checkOutput({tag, ".o_ctrl"}, 64'(o_ctrl), 64'(ec));
    checkOutput({tag, ".o_data"}, o_data, ed);
    checkOutput({tag, ".o_occupancy"}, 64'(o_occupancy), 64'(eo));
    checkOutput({tag, ".o_ready"}, 64'(o_ready), 64'(er));
    checkOutput({tag, ".o_stall_cnt"}, 64'(o_stall_cnt), 64'(es));
  endtask

  // Advance one active (falling) edge and settle before sampling.
  task automatic stepEdge();
    @(negedge clk);
    #2;
  endtask

  task automatic addVec(input string n, input logic v,
                        input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                        input logic r, input logic f, input logic ev,
                        input logic [CTRL_W-1:0] ec,
                        input logic [DATA_W-1:0] ed, input logic [1:0] eo,
                        input logic er, input logic [CNT_W-1:0] es);
    vec_t t;
    t.name = n; t.valid = v; t.ctrl = c; t.data = d; t.ready = r; t.flush = f;
    t.exp_valid = ev; t.exp_ctrl = ec; t.exp_data = ed; t.exp_occ = eo;
    t.exp_ready = er; t.exp_stall = es;
    vecs.push_back(t);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);

    // Expected outputs are after the edge that consumes each row's inputs.
    addVec("single_in",   1, 4'hA, 64'h1234, 1, 0, 1, 4'hA, 64'h1234, 2'd1, 1, 0);
    addVec("single_out",  0, 4'h0, 64'h0,    1, 0, 0, 4'h0, 64'h1234, 2'd0, 1, 0);
    for (int k = 1; k <= 8; k++) begin
      addVec($sformatf("stream_%0d", k), 1, 4'(k), 64'(k), 1, 0,
             1, 4'(k), 64'(k), 2'd1, 1, 0);
    end
    addVec("stream_drain",0, 4'h0, 64'h0,    1, 0, 0, 4'h0, 64'h8,    2'd0, 1, 0);
    addVec("skid_5",      1, 4'h5, 64'h5,    0, 0, 1, 4'h5, 64'h5,    2'd1, 1, 0);
    addVec("skid_6",      1, 4'h6, 64'h6,    0, 0, 1, 4'h5, 64'h5,    2'd2, 0, 1);
    addVec("skid_7_held", 1, 4'h7, 64'h7,    0, 0, 1, 4'h5, 64'h5,    2'd2, 0, 2);
    addVec("skid_out_6",  1, 4'h7, 64'h7,    1, 0, 1, 4'h6, 64'h6,    2'd1, 1, 2);
    addVec("skid_out_7",  1, 4'h7, 64'h7,    1, 0, 1, 4'h7, 64'h7,    2'd1, 1, 2);
    addVec("skid_drain",  0, 4'h0, 64'h0,    1, 0, 0, 4'h0, 64'h7,    2'd0, 1, 2);
    addVec("fl_fill_a",   1, 4'h1, 64'h11,   0, 0, 1, 4'h1, 64'h11,   2'd1, 1, 2);
    addVec("fl_fill_b",   1, 4'h2, 64'h22,   0, 0, 1, 4'h1, 64'h11,   2'd2, 0, 3);
    addVec("flush_full",  1, 4'h9, 64'h9,    0, 1, 0, 4'h0, 64'h11,   2'd0, 1, 3);
    addVec("post_flush",  0, 4'h0, 64'h0,    1, 0, 0, 4'h0, 64'h11,   2'd0, 1, 3);
    addVec("flush_empty", 1, 4'h3, 64'h33,   1, 1, 0, 4'h0, 64'h11,   2'd0, 1, 3);
    addVec("after_drop",  0, 4'h0, 64'h0,    1, 0, 0, 4'h0, 64'h11,   2'd0, 1, 3);

    #3;
    checkAll("reset", 0, 4'h0, 64'h0, 2'd0, 0, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid, vecs[i].ctrl, vecs[i].data,
                    vecs[i].ready, vecs[i].flush);
      stepEdge();
      checkAll(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_ctrl,
               vecs[i].exp_data, vecs[i].exp_occ, vecs[i].exp_ready,
               vecs[i].exp_stall);
    end

    // Stall saturation: hold one entry with downstream stalled.
    doReset();
    applyStimulus(1'b1, 4'h5, 64'h55, 1'b0, 1'b0);
    stepEdge();
    checkAll("sat_load", 1, 4'h5, 64'h55, 2'd1, 1, 0);
    applyStimulus(1'b0, 4'h0, 64'h0, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      stepEdge();
      checkOutput($sformatf("sat_edge%0d.o_stall_cnt", k),
                  64'(o_stall_cnt), (k > 7) ? 64'd7 : 64'(k));
    end
    checkOutput("sat_hold.o_data", o_data, 64'h55);

    // Asynchronous reset while full: outputs clear without a clock edge.
    applyStimulus(1'b1, 4'h6, 64'h66, 1'b0, 1'b0);
    stepEdge();
    checkAll("pre_areset", 1, 4'h5, 64'h55, 2'd2, 0, 7);
    applyStimulus(1'b0, 4'h0, 64'h0, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    checkAll("areset", 0, 4'h0, 64'h0, 2'd0, 0, 0);
    rst = 1'b0;
    #1;
    checkOutput("areset_release.o_ready", 64'(o_ready), 64'd1);
    applyStimulus(1'b0, 4'h0, 64'h0, 1'b1, 1'b0);
    stepEdge();
    checkAll("post_areset", 0, 4'h0, 64'h0, 2'd0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_skid_buff.md
Name: pipe_skid_buff

Overview:
Parametrised inter-stage pipeline buffer: the next generation of the core's fixed-field stage buffers. It carries a packed control field and data payload between pipeline stages using a valid/ready handshake. A two-entry skid store gives full throughput under back-pressure. It adds flush (bubble insertion) and a saturating stall counter for performance monitoring.

Parameters:
CTRL_W, 4, width of the control field (WB/Mem bits); forced to 0 on bubbles
DATA_W, 64, width of the data payload (e.g. MemData, alu, Rdst and SP packed)
CNT_W, 16, width of the stall counter

Ports:
clk  input  1  stage clock; all state updates on the falling edge
rst  input  1  asynchronous, active-high reset
i_valid  input  1  upstream has a valid entry
o_ready  output  1  buffer can accept an entry this edge
i_ctrl  input  CTRL_W  upstream control field
i_data  input  DATA_W  upstream payload
o_valid  output  1  head entry valid
i_ready  input  1  downstream accepts the head entry this edge
o_ctrl  output  CTRL_W  head control field; 0 whenever o_valid=0
o_data  output  DATA_W  head payload
i_flush  input  1  discard all held entries (branch/exception kill)
o_occupancy  output  2  number of held entries: 0, 1 or 2
o_stall_cnt  output  CNT_W  edges on which the head was valid but not accepted

Behaviour:
- Reset (rst high, asynchronous): state EMPTY, main/skid valid=0, main/skid ctrl and data=0, o_stall_cnt=0, o_occupancy=0; o_ready forced 0 while rst high.
- in_fire = i_valid & o_ready; out_fire = o_valid & i_ready; both are sampled on the falling clk edge.
- o_ready = !rst & (state != FULL); it depends only on registered state, not on i_ready.
- o_valid = main_valid; o_ctrl = main_valid ? main_ctrl : 0; o_data = main_data (retains last value when invalid).
- States:
  - EMPTY (occ 0): in_fire -> ONE, main<=input.
  - ONE (occ 1), in_fire & out_fire -> ONE, main<=input.
  - ONE, in_fire only -> FULL, skid<=input, main unchanged.
  - ONE, out_fire only -> EMPTY.
  - ONE, neither -> hold.
  - FULL (occ 2): in_fire impossible; out_fire -> ONE, main<=skid, skid_valid<=0; otherwise hold.
- Latency: 1 falling edge from in_fire to o_valid when EMPTY. Throughput: 1 entry per cycle with i_ready held high.
- Ordering is strictly FIFO; no entry is duplicated or dropped except by flush.
- Flush has priority over all transfers. On an edge with i_flush=1 the next state is EMPTY and both valids clear. An input offered on that edge is dropped even if o_ready=1. A head accepted by downstream on that same edge counts as consumed upstream-side only.
- Stall counter: +1 on each edge with o_valid & !i_ready & !i_flush; saturates at 2^CNT_W-1 (no wrap). Cleared only by rst; flush does not clear it.
- Reset mid-operation: all entries are lost immediately (asynchronous); outputs return to reset values within the same cycle.

Decomposition:
- pipe_buff_pkg holds:
  - the state typedef: EMPTY=2'd0, ONE=2'd1, FULL=2'd2, with 2'd3 illegal and recovering to EMPTY;
  - the occupancy encoding constants.
- One sub-module, sat_counter (width CNT_W, inc enable, async reset, saturating), used for o_stall_cnt.
- Payload packing of stage fields into i_data/o_data is done by the instantiating stage, not here.

Test Plan:
- Reset then single entry: rst pulse; i_valid=1, i_ctrl=4'hA, i_data=64'h1234 for one edge, i_ready=1 -> o_valid=1, o_ctrl=A, o_data=1234 after 1 edge; o_occupancy=1; next edge o_valid=0, o_ctrl=0.
- Streaming: i_valid=1 with data 1..8 on consecutive edges, i_ready=1 -> outputs 1..8 in order, one per edge, o_ready never low, stall_cnt=0.
- Back-pressure skid: send 5,6,7 with i_ready=0 -> after 2 edges o_occupancy=2, o_ready=0, 7 is held upstream. Raise i_ready -> outputs 5,6,7 in order with no loss; stall_cnt=2.
- Flush while FULL: occupancy 2 with i_valid=1 data 9 and i_flush=1 -> next edge o_valid=0, o_ctrl=0, o_occupancy=0, o_ready=1; 9 is never output.
- Stall saturation: CNT_W=3, o_valid=1, i_ready=0 for 10 edges -> o_stall_cnt stops at 7.
- Async reset mid-stream: rst asserted between edges while FULL -> o_valid, o_ctrl, o_occupancy and o_stall_cnt are 0 immediately, without waiting for a clk edge.
